alu_muldiv: RTL and testbench

//  Parametrised successor ALU for the MIPS datapath: registered single-cycle integer ops plus an

---
 rtl/alu_pkg.sv | 27 ++
 rtl/md_iter.sv | 64 ++++++
 rtl/alu_muldiv.sv | 95 +++++++++
 tb/tb_alu_muldiv.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and mul/div state encodings for alu_muldiv
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLL   = 4'b0011,
        OP_SRL   = 4'b0100,
        OP_SRA   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_SLTU  = 4'b1000,
        OP_MULT  = 4'b1010,
        OP_MULTU = 4'b1011,
        OP_DIV   = 4'b1100,
        OP_DIVU  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_e;

    // 1010..1101 are the only multi-cycle codes
    function automatic logic is_md(input logic [3:0] op);
        return op[3] & (op[2] ^ op[1]);
    endfunction

endpackage

// File: rtl/md_iter.sv
// md_iter: shift-add multiplier / restoring divider datapath, one bit per step
// Ports: load captures operand magnitudes and sign flags; step advances one bit;
//        done flags the final step; hi/lo present the sign-corrected result.
module md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic             div_op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    // p holds {upper, lower}: product accumulator/multiplier, or remainder/quotient
    logic [2*WIDTH-1:0] p, prod;
    logic [WIDTH-1:0]   m, a_mag, b_mag, div_r;
    logic [WIDTH:0]     mul_sum, div_t;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r, div_ge;

    assign a_mag   = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (sgn && b[WIDTH-1]) ? -b : b;
    assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    assign div_t   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign div_ge  = div_t >= {1'b0, m};
    assign div_r   = div_ge ? div_t[WIDTH-1:0] - m : div_t[WIDTH-1:0];
    assign done    = cnt == '0;
    assign prod    = neg_q ? -p : p;
    assign hi      = is_div ? (neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    assign lo      = is_div ? (neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0]) : prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p      <= '0;
            m      <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (load) begin
            p      <= {{WIDTH{1'b0}}, a_mag};
            m      <= b_mag;
            cnt    <= CW'(WIDTH - 1);
            is_div <= div_op;
            // divide by zero keeps the raw all-ones quotient; remainder still follows the dividend
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]) & ~(div_op & (b == '0));
            neg_r  <= div_op & sgn & a[WIDTH-1];
        end else if (step) begin
            p   <= is_div ? {div_r, p[WIDTH-2:0], div_ge} : {mul_sum, p[WIDTH-1:1]};
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered single-cycle ALU plus iterative mul/div unit writing HI/LO
// Ports: op_valid/op_ready request handshake (ready only in IDLE); alucontrol/srca/srcb
//        operation; res_valid one-cycle result pulse with aluout, hi, lo; busy = !op_ready.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             res_valid,
    output logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    md_state_e          state, state_n;
    alu_op_e            op;
    logic [WIDTH-1:0]   alu_res, md_hi, md_lo;
    logic [SHAMT_W-1:0] shamt;
    logic               accept, md, load, step, done;

    assign op       = alu_op_e'(alucontrol);
    assign md       = is_md(alucontrol);
    assign op_ready = state == IDLE;
    assign busy     = ~op_ready;
    assign accept   = op_valid & op_ready;
    assign shamt    = srca[SHAMT_W-1:0];
    assign load     = accept & md;
    assign step     = state == MUL || state == DIV;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = srca & srcb;
            OP_OR:   alu_res = srca | srcb;
            OP_ADD:  alu_res = srca + srcb;
            OP_SUB:  alu_res = srca - srcb;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, srca < srcb};
            OP_SLL:  alu_res = srcb << shamt;
            OP_SRL:  alu_res = srcb >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(srcb) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = load ? (alucontrol[2] ? DIV : MUL) : IDLE;
            MUL, DIV: state_n = done ? FIX : state;
            default:  state_n = IDLE;
        endcase
    end

    md_iter #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .step   (step),
        .div_op (alucontrol[2]),
        .sgn    (~alucontrol[0]),
        .a      (srca),
        .b      (srcb),
        .done   (done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            aluout    <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state     <= state_n;
            res_valid <= (accept & ~md) | (state == FIX);
            if (accept & ~md)
                aluout <= alu_res;
            else if (state == FIX)
                {aluout, hi, lo} <= {md_lo, md_hi, md_lo};
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for 32- and 16-bit alu_muldiv against an arithmetic model
module tb_alu_muldiv;
    import alu_pkg::*;

    typedef struct {
        int          d;
        int          cyc;
        logic [31:0] o, h, l;
        logic        md;
    } exp_t;

    logic        clk = 1'b0, resetn = 1'b0, v0 = 1'b0, v1 = 1'b0;
    logic [3:0]  alucontrol = '0;
    logic [31:0] srca = '0, srcb = '0;
    wire         r0, r1, rv0, rv1, b0, b1;
    wire  [31:0] o0, h0, l0;
    wire  [15:0] o1, h1, l1;

    exp_t        q[$];
    exp_t        e;
    int          cyc = 0, checks = 0, errors = 0;
    int          busy_from[2] = '{0, 0}, busy_to[2] = '{0, 0};
    logic [31:0] mhi[2] = '{0, 0}, mlo[2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .op_valid(v0), .op_ready(r0), .alucontrol(alucontrol),
        .srca(srca), .srcb(srcb), .res_valid(rv0), .aluout(o0), .hi(h0), .lo(l0), .busy(b0)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .resetn(resetn), .op_valid(v1), .op_ready(r1), .alucontrol(alucontrol),
        .srca(srca[15:0]), .srcb(srcb[15:0]), .res_valid(rv1), .aluout(o1), .hi(h1), .lo(l1), .busy(b1)
    );

    function automatic logic [31:0] get_o(int d); return d == 1 ? {16'd0, o1} : o0; endfunction
    function automatic logic [31:0] get_h(int d); return d == 1 ? {16'd0, h1} : h0; endfunction
    function automatic logic [31:0] get_l(int d); return d == 1 ? {16'd0, l1} : l0; endfunction
    function automatic logic get_r(int d);  return d == 1 ? r1 : r0;  endfunction
    function automatic logic get_rv(int d); return d == 1 ? rv1 : rv0; endfunction
    function automatic logic get_b(int d);  return d == 1 ? b1 : b0;  endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on W-bit values held in 64-bit containers
    function automatic exp_t model(int d, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int          w    = (d == 1) ? 16 : 32;
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] ua   = {32'd0, a} & mask;
        logic [63:0] ub   = {32'd0, b} & mask;
        longint      sa   = a[w-1] ? $signed(ua) - (longint'(1) << w) : $signed(ua);
        longint      sb   = b[w-1] ? $signed(ub) - (longint'(1) << w) : $signed(ub);
        int          sh   = int'(ua & 64'(w - 1));
        logic [63:0] r    = '0;
        exp_t        x;
        x.d  = d;
        x.h  = mhi[d];
        x.l  = mlo[d];
        x.md = 1'b0;
        x.cyc = 0;
        case (op)
            OP_AND:   r = ua & ub;
            OP_OR:    r = ua | ub;
            OP_ADD:   r = ua + ub;
            OP_SUB:   r = ua - ub;
            OP_SLT:   r = {63'd0, sa < sb};
            OP_SLTU:  r = {63'd0, ua < ub};
            OP_SLL:   r = ub << sh;
            OP_SRL:   r = ub >> sh;
            OP_SRA:   r = 64'(sb >>> sh);
            OP_MULT:  begin x.md = 1'b1; r = 64'(sa * sb); x.h = 32'((r >> w) & mask); end
            OP_MULTU: begin x.md = 1'b1; r = ua * ub;      x.h = 32'((r >> w) & mask); end
            OP_DIV: begin
                x.md = 1'b1;
                if (ub == 0) begin r = mask; x.h = ua[31:0]; end
                else begin r = 64'(sa / sb); x.h = 32'(64'(sa % sb) & mask); end
            end
            OP_DIVU: begin
                x.md = 1'b1;
                if (ub == 0) begin r = mask; x.h = ua[31:0]; end
                else begin r = ua / ub; x.h = 32'((ua % ub) & mask); end
            end
            default:  r = '0;
        endcase
        x.o = 32'(r & mask);
        if (x.md) x.l = x.o;
        return x;
    endfunction

    // Waits for op_ready (leaving any previous request asserted), then presents one request
    task automatic issue(int d, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int   n = 0;
        exp_t x;
        @(negedge clk);
        while (!get_r(d)) begin
            if (++n > 200) begin
                checks++;
                errors++;
                $display("FAIL op_ready timeout dut%0d", d);
                return;
            end
            @(negedge clk);
        end
        alucontrol = op;
        srca = a;
        srcb = b;
        v0 = (d == 0);
        v1 = (d == 1);
        x = model(d, op, a, b);
        x.cyc = cyc + (x.md ? ((d == 1) ? 18 : 34) : 1);
        if (x.md) begin
            mhi[d] = x.h;
            mlo[d] = x.l;
            busy_from[d] = cyc + 1;
            busy_to[d] = x.cyc;
        end
        q.push_back(x);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic check_reset_state(int d);
        chk("rst_aluout", d, get_o(d), 0);
        chk("rst_hi", d, get_h(d), 0);
        chk("rst_lo", d, get_l(d), 0);
        chk("rst_res_valid", d, 32'(get_rv(d)), 0);
        chk("rst_op_ready", d, 32'(get_r(d)), 1);
        chk("rst_busy", d, 32'(get_b(d)), 0);
    endtask

    task automatic reset_mid_mult(int d);
        issue(d, OP_MULT, 32'hFFFFFFFD, 32'd5);
        repeat (9) @(negedge clk);
        #1;
        resetn = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        q.delete();
        busy_to[d] = 0;
        mhi[d] = '0;
        mlo[d] = '0;
        #1;
        check_reset_state(d);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'hFFFF8000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: handshake invariants every cycle, scoreboard pop on each result pulse
    always @(negedge clk) begin
        if (resetn) begin
            for (int d = 0; d < 2; d++) begin
                chk("op_ready", d, 32'(get_r(d)), 32'(!(cyc >= busy_from[d] && cyc < busy_to[d])));
                chk("busy", d, 32'(get_b(d)), 32'(!get_r(d)));
                if (get_rv(d)) begin
                    if (q.size() == 0 || q[0].d != d) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected res_valid dut%0d at cycle %0d", d, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("latency", d, 32'(cyc), 32'(e.cyc));
                        chk("aluout", d, get_o(d), e.o);
                        chk("hi", d, get_h(d), e.h);
                        chk("lo", d, get_l(d), e.l);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        resetn = 1'b1;
        issue(0, OP_ADD,   32'h7FFFFFFF, 32'd1);
        issue(0, OP_SUB,   32'd0,        32'd1);
        issue(0, OP_SLT,   32'hFFFFFFFF, 32'd1);
        issue(0, OP_SLTU,  32'hFFFFFFFF, 32'd1);
        issue(0, OP_SRA,   32'd4,        32'h80000000);
        issue(0, 4'b1001,  32'd3,        32'd4);
        issue(0, OP_MULT,  32'hFFFFFFFD, 32'd5);
        issue(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(0, OP_DIV,   32'hFFFFFFF9, 32'd2);
        issue(0, OP_DIVU,  32'd7,        32'd0);
        issue(0, OP_DIV,   32'h80000000, 32'hFFFFFFFF);
        issue(0, OP_DIV,   32'hFFFFFFF9, 32'd0);
        issue(0, OP_SLL,   32'd35,       32'h0000F00F);
        for (int i = 0; i < 6; i++) issue(0, OP_ADD, 32'(i), 32'h10);
        idle();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 3) == 0) idle();
                issue(d, 4'($urandom_range(0, 15)), pick(), pick());
            end
            idle();
        end
        issue(1, OP_MULT, 32'h0000FFFD, 32'd5);
        issue(1, OP_DIV,  32'h00008000, 32'h0000FFFF);
        idle();
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drained", 0, 32'(q.size()), 0);
        reset_mid_mult(0);
        reset_mid_mult(1);
        issue(0, OP_OR, 32'hA5A50000, 32'h00005A5A);
        idle();
        repeat (3) @(negedge clk);
        chk("drained_end", 0, 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
